// File: rtl/sensor_sequencer_if.sv
// Control and readout bundle between the camera controller, the sequencer
// and the downstream row readout block.
interface sensor_sequencer_if #(
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int RAMP_WIDTH         = 8,
  parameter int EXPOSE_WIDTH       = 8
) ();
  logic                          start;
  logic                          continuous;
  logic [EXPOSE_WIDTH-1:0]       expose_time;
  logic                          row_ready;
  logic                          p_erase;
  logic                          p_expose;
  logic                          p_expose_clk;
  logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select;
  logic [RAMP_WIDTH-1:0]         p_dRamp;
  logic                          row_valid;
  logic                          busy;
  logic                          frame_done;

  // Controller / readout side
  modport master (
    output start, continuous, expose_time, row_ready,
    input  p_erase, p_expose, p_expose_clk, p_row_select, p_dRamp,
           row_valid, busy, frame_done
  );

  // Sequencer side
  modport slave (
    input  start, continuous, expose_time, row_ready,
    output p_erase, p_expose, p_expose_clk, p_row_select, p_dRamp,
           row_valid, busy, frame_done
  );
endinterface

// File: rtl/sensor_sequencer.sv
// Pixel-array sequencer: erase, exposure, then per-row ramp conversion with
// a valid/ready handoff of each converted row. All outputs are registers.
module sensor_sequencer #(
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int RAMP_WIDTH         = 8,
  parameter int EXPOSE_WIDTH       = 8,
  parameter int ERASE_CYCLES       = 5
) (
  input logic               clk,
  input logic               reset,
  sensor_sequencer_if.slave bus
);
  localparam int ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int ERASE_W = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
  localparam int CNT_W   = (EXPOSE_WIDTH > ERASE_W) ? EXPOSE_WIDTH : ERASE_W;

  localparam logic [CNT_W-1:0]              ERASE_LAST = CNT_W'(ERASE_CYCLES - 1);
  localparam logic [ROW_W-1:0]              ROW_LAST   = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [RAMP_WIDTH-1:0]         RAMP_MAX   = {RAMP_WIDTH{1'b1}};
  localparam logic [PIXEL_ARRAY_HEIGHT-1:0] ROW0_SEL   = PIXEL_ARRAY_HEIGHT'(1);

  // Reject parameter sets the sequencing cannot honour
  if (ERASE_CYCLES < 1) begin : g_bad_erase
    $error("ERASE_CYCLES must be at least 1");
  end
  if (PIXEL_ARRAY_WIDTH < 1) begin : g_bad_width
    $error("PIXEL_ARRAY_WIDTH must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ    = 3'd4
  } state_t;

  state_t                        state_r;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              exp_last_r;
  logic [ROW_W-1:0]              row_r;
  logic                          p_erase_r;
  logic                          p_expose_r;
  logic                          p_expose_clk_r;
  logic [PIXEL_ARRAY_HEIGHT-1:0] p_row_select_r;
  logic [RAMP_WIDTH-1:0]         p_dramp_r;
  logic                          row_valid_r;
  logic                          busy_r;
  logic                          frame_done_r;

  // Last exposure cycle index; a zero request still exposes for one cycle
  function automatic logic [CNT_W-1:0] exp_last_of(input logic [EXPOSE_WIDTH-1:0] t);
    logic [CNT_W-1:0] t_ext;
    t_ext = CNT_W'(t);
    if (t_ext == {CNT_W{1'b0}}) begin
      return {CNT_W{1'b0}};
    end else begin
      return t_ext - CNT_W'(1);
    end
  endfunction

  // Main sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      cnt_r          <= {CNT_W{1'b0}};
      exp_last_r     <= {CNT_W{1'b0}};
      row_r          <= {ROW_W{1'b0}};
      p_erase_r      <= 1'b0;
      p_expose_r     <= 1'b0;
      p_expose_clk_r <= 1'b0;
      p_row_select_r <= {PIXEL_ARRAY_HEIGHT{1'b0}};
      p_dramp_r      <= {RAMP_WIDTH{1'b0}};
      row_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      frame_done_r   <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            state_r    <= ERASE;
            busy_r     <= 1'b1;
            p_erase_r  <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
            exp_last_r <= exp_last_of(bus.expose_time);
          end
        end
        ERASE: begin
          if (cnt_r == ERASE_LAST) begin
            state_r        <= EXPOSE;
            p_erase_r      <= 1'b0;
            p_expose_r     <= 1'b1;
            p_expose_clk_r <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        EXPOSE: begin
          if (cnt_r == exp_last_r) begin
            state_r        <= CONVERT;
            p_expose_r     <= 1'b0;
            p_expose_clk_r <= 1'b0;
            row_r          <= {ROW_W{1'b0}};
            p_row_select_r <= ROW0_SEL;
            p_dramp_r      <= {RAMP_WIDTH{1'b0}};
          end else begin
            cnt_r          <= cnt_r + CNT_W'(1);
            p_expose_clk_r <= ~p_expose_clk_r;
          end
        end
        CONVERT: begin
          // End of ramp is the all-ones code; the ramp then holds there
          if (p_dramp_r == RAMP_MAX) begin
            state_r     <= READ;
            row_valid_r <= 1'b1;
          end else begin
            p_dramp_r <= p_dramp_r + RAMP_WIDTH'(1);
          end
        end
        READ: begin
          if (bus.row_ready) begin
            row_valid_r <= 1'b0;
            p_dramp_r   <= {RAMP_WIDTH{1'b0}};
            if (row_r != ROW_LAST) begin
              state_r        <= CONVERT;
              row_r          <= row_r + ROW_W'(1);
              p_row_select_r <= p_row_select_r << 1;
            end else begin
              row_r          <= {ROW_W{1'b0}};
              p_row_select_r <= {PIXEL_ARRAY_HEIGHT{1'b0}};
              frame_done_r   <= 1'b1;
              if (bus.continuous) begin
                state_r    <= ERASE;
                p_erase_r  <= 1'b1;
                cnt_r      <= {CNT_W{1'b0}};
                exp_last_r <= exp_last_of(bus.expose_time);
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_r        <= IDLE;
          cnt_r          <= {CNT_W{1'b0}};
          row_r          <= {ROW_W{1'b0}};
          p_erase_r      <= 1'b0;
          p_expose_r     <= 1'b0;
          p_expose_clk_r <= 1'b0;
          p_row_select_r <= {PIXEL_ARRAY_HEIGHT{1'b0}};
          p_dramp_r      <= {RAMP_WIDTH{1'b0}};
          row_valid_r    <= 1'b0;
          busy_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p_erase      = p_erase_r;
  assign bus.p_expose     = p_expose_r;
  assign bus.p_expose_clk = p_expose_clk_r;
  assign bus.p_row_select = p_row_select_r;
  assign bus.p_dRamp      = p_dramp_r;
  assign bus.row_valid    = row_valid_r;
  assign bus.busy         = busy_r;
  assign bus.frame_done   = frame_done_r;
endmodule

// File: tb/tb_sensor_sequencer.sv
// Scoreboard bench for sensor_sequencer: default instance A plus a small
// instance B (RAMP_WIDTH=4, 8 rows, ERASE_CYCLES=1).
module tb_sensor_sequencer;
  logic clk = 1'b0;
  logic reset_a;
  logic reset_b;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    bit         done;
    int         cyc;
    logic [7:0] rsel;
    logic [7:0] ramp;
  } evt_t;

  evt_t qa[$];
  evt_t qb[$];

  sensor_sequencer_if #(.PIXEL_ARRAY_HEIGHT(4), .RAMP_WIDTH(8), .EXPOSE_WIDTH(8)) ifa ();
  sensor_sequencer_if #(.PIXEL_ARRAY_HEIGHT(8), .RAMP_WIDTH(4), .EXPOSE_WIDTH(8)) ifb ();

  sensor_sequencer #(
    .PIXEL_ARRAY_HEIGHT(4), .PIXEL_ARRAY_WIDTH(4), .RAMP_WIDTH(8),
    .EXPOSE_WIDTH(8), .ERASE_CYCLES(5)
  ) dut_a (.clk(clk), .reset(reset_a), .bus(ifa));

  sensor_sequencer #(
    .PIXEL_ARRAY_HEIGHT(8), .PIXEL_ARRAY_WIDTH(4), .RAMP_WIDTH(4),
    .EXPOSE_WIDTH(8), .ERASE_CYCLES(1)
  ) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

  always #5 clk = ~clk;

  // Cycle label: the interval after edge n reads n+1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Expected row handshakes and frame_done for one frame started at edge k
  task automatic push_frame(input int which, input int k, input int erase, input int expn,
                            input int h, input int rmax, input int stall_row,
                            input int stall, input int nrows);
    evt_t e;
    int   t;
    t = k + erase + expn;
    for (int r = 0; r < nrows; r++) begin
      t = t + rmax + 2;
      if (r == stall_row) t = t + stall;
      e.done = 1'b0; e.cyc = t; e.rsel = 8'(1 << r); e.ramp = 8'(rmax);
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (nrows == h) begin
      e.done = 1'b1; e.cyc = t + 1; e.rsel = 8'd0; e.ramp = 8'd0;
      if (which == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  task automatic pop_check(input int which, input bit done, input logic [7:0] rsel,
                           input logic [7:0] ramp);
    evt_t e;
    if ((which == 0 && qa.size() == 0) || (which == 1 && qb.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event inst%0d @cycle %0d: got done=%0d, required no event",
               which, cyc, done);
      return;
    end
    if (which == 0) e = qa.pop_front(); else e = qb.pop_front();
    chk($sformatf("evt_kind%0d", which), int'(done), int'(e.done));
    chk($sformatf("evt_cycle%0d", which), cyc, e.cyc);
    if (!done) begin
      chk($sformatf("evt_rsel%0d", which), int'(rsel), int'(e.rsel));
      chk($sformatf("evt_ramp%0d", which), int'(ramp), int'(e.ramp));
    end
  endtask

  // Monitor for instance A: pop on each handshake or frame_done
  always @(negedge clk) begin
    #2;
    if (reset_a === 1'b1) begin
      if (ifa.row_valid && ifa.row_ready)
        pop_check(0, 1'b0, 8'(ifa.p_row_select), 8'(ifa.p_dRamp));
      if (ifa.frame_done) pop_check(0, 1'b1, 8'd0, 8'd0);
    end
  end

  // Monitor for instance B
  always @(negedge clk) begin
    #2;
    if (reset_b === 1'b1) begin
      if (ifb.row_valid && ifb.row_ready)
        pop_check(1, 1'b0, 8'(ifb.p_row_select), 8'(ifb.p_dRamp));
      if (ifb.frame_done) pop_check(1, 1'b1, 8'd0, 8'd0);
    end
  end

  // Erase/expose phase of instance A for a frame started at edge k
  task automatic check_front(input int k, input int expn);
    bit x;
    for (int c = k + 1; c <= k + 6 + expn; c++) begin
      wait_cyc(c);
      x = (c > k + 5) && (c <= k + 5 + expn);
      chk("erase", int'(ifa.p_erase), int'(c <= k + 5));
      chk("expose", int'(ifa.p_expose), int'(x));
      chk("expose_clk", int'(ifa.p_expose_clk), x ? ((c - k - 6) % 2) : 0);
      chk("front_rsel", int'(ifa.p_row_select), (c == k + 6 + expn) ? 1 : 0);
      chk("front_busy", int'(ifa.busy), 1);
    end
  endtask

  task automatic do_start(input int expn, input bit cont, output int k);
    ifa.expose_time = 8'(expn);
    ifa.continuous  = cont;
    ifa.start       = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    k = cyc - 1;
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_erase"}, int'(ifa.p_erase), 0);
    chk({tag, "_expose"}, int'(ifa.p_expose), 0);
    chk({tag, "_expose_clk"}, int'(ifa.p_expose_clk), 0);
    chk({tag, "_rsel"}, int'(ifa.p_row_select), 0);
    chk({tag, "_ramp"}, int'(ifa.p_dRamp), 0);
    chk({tag, "_row_valid"}, int'(ifa.row_valid), 0);
    chk({tag, "_busy"}, int'(ifa.busy), 0);
    chk({tag, "_frame_done"}, int'(ifa.frame_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset_a = 1'b0; reset_b = 1'b0;
    ifa.start = 1'b0; ifa.continuous = 1'b0; ifa.expose_time = 8'd10; ifa.row_ready = 1'b1;
    ifb.start = 1'b0; ifb.continuous = 1'b0; ifb.expose_time = 8'd2;  ifb.row_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_a("rst");
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_a("idle");

    // 1: nominal frame
    do_start(10, 1'b0, k);
    push_frame(0, k, 5, 10, 4, 255, -1, 0, 4);
    check_front(k, 10);
    wait_cyc(k + 1043);
    chk("t1_busy_last_read", int'(ifa.busy), 1);
    wait_cyc(k + 1044);
    chk("t1_busy_fall", int'(ifa.busy), 0);
    wait_cyc(k + 1046);

    // 2: backpressure at row 1
    do_start(10, 1'b0, k);
    push_frame(0, k, 5, 10, 4, 255, 1, 20, 4);
    wait_cyc(k + 528);
    ifa.row_ready = 1'b0;
    for (int c = k + 529; c <= k + 548; c++) begin
      wait_cyc(c);
      chk("t2_hold_valid", int'(ifa.row_valid), 1);
      chk("t2_hold_rsel", int'(ifa.p_row_select), 2);
      chk("t2_hold_ramp", int'(ifa.p_dRamp), 255);
    end
    wait_cyc(k + 549);
    ifa.row_ready = 1'b1;
    wait_cyc(k + 550);
    chk("t2_row2_rsel", int'(ifa.p_row_select), 4);
    chk("t2_row2_ramp", int'(ifa.p_dRamp), 0);
    chk("t2_row2_valid", int'(ifa.row_valid), 0);
    wait_cyc(k + 1066);

    // 3: continuous mode, new exposure length for frame two
    do_start(10, 1'b1, k);
    ifa.expose_time = 8'd3;
    push_frame(0, k, 5, 10, 4, 255, -1, 0, 4);
    push_frame(0, k + 1043, 5, 3, 4, 255, -1, 0, 4);
    wait_cyc(k + 1044);
    chk("t3_erase_after_done", int'(ifa.p_erase), 1);
    chk("t3_busy_kept", int'(ifa.busy), 1);
    ifa.continuous = 1'b0;
    check_front(k + 1043, 3);
    wait_cyc(k + 1043 + 1039);

    // 4: zero exposure, start held high for most of the frame
    ifa.expose_time = 8'd0;
    ifa.start = 1'b1;
    @(negedge clk);
    k = cyc - 1;
    push_frame(0, k, 5, 1, 4, 255, -1, 0, 4);
    check_front(k, 1);
    wait_cyc(k + 1000);
    ifa.start = 1'b0;
    wait_cyc(k + 1036);
    chk("t4_idle_busy", int'(ifa.busy), 0);

    // 5: asynchronous reset mid-ramp of row 2
    do_start(10, 1'b0, k);
    push_frame(0, k, 5, 10, 4, 255, -1, 0, 2);
    wait_cyc(k + 600);
    chk("t5_pre_rsel", int'(ifa.p_row_select), 4);
    chk("t5_pre_ramp", int'(ifa.p_dRamp), 70);
    reset_a = 1'b0;
    #1;
    check_zero_a("t5_async");
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    do_start(10, 1'b0, k);
    push_frame(0, k, 5, 10, 4, 255, -1, 0, 4);
    check_front(k, 10);
    wait_cyc(k + 1046);

    // 6: small instance B
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    k = cyc - 1;
    push_frame(1, k, 1, 2, 8, 15, -1, 0, 8);
    chk("t6_erase", int'(ifb.p_erase), 1);
    wait_cyc(k + 2);
    chk("t6_expose", int'(ifb.p_expose), 1);
    wait_cyc(k + 4);
    chk("t6_rsel0", int'(ifb.p_row_select), 1);
    chk("t6_ramp0", int'(ifb.p_dRamp), 0);
    wait_cyc(k + 139);
    chk("t6_last_rsel", int'(ifb.p_row_select), 128);
    wait_cyc(k + 142);

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sensor_sequencer.md
Name: sensor_sequencer

Overview:
Second-generation pixel-array control FSM. It drives erase, exposure and row-by-row ramp conversion for a PIXEL_ARRAY_HEIGHT-row sensor, with the following additions:
- a run-time exposure length;
- a configurable ramp width;
- single-shot or continuous frame mode;
- a valid/ready handshake per converted row toward the downstream readout block.

It sits between the top-level camera controller and the pixel array / ADC ramp DAC.

Parameters:
PIXEL_ARRAY_HEIGHT, 4, number of rows; width of p_row_select
PIXEL_ARRAY_WIDTH, 4, pixels per row; informational only, no logic depends on it
RAMP_WIDTH, 8, width of p_dRamp; ramp runs 0..2^RAMP_WIDTH-1
EXPOSE_WIDTH, 8, width of expose_time
ERASE_CYCLES, 5, cycles p_erase is held high (minimum 1)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request one frame; sampled only in IDLE
continuous  input  1  1 = begin a new frame automatically after frame end; sampled at frame end
expose_time  input  EXPOSE_WIDTH  exposure length in cycles; latched on accepted start
row_ready  input  1  downstream ready to take the current row
p_erase  output  1  pixel erase
p_expose  output  1  pixel expose enable
p_expose_clk  output  1  registered exposure clock; toggles every cycle during EXPOSE
p_row_select  output  PIXEL_ARRAY_HEIGHT  one-hot row select
p_dRamp  output  RAMP_WIDTH  ADC ramp code
row_valid  output  1  current row conversion complete; held until handshake
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse after the last row handshake

Behaviour:
- reset=0, asynchronously and at any time including mid-frame:
  - state IDLE; row index 0; all outputs 0.
  - Synchronous release takes effect at the first rising edge with reset=1.
- All outputs are registered. None is combinational from inputs.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE:
  - Outputs 0.
  - start=1 at edge k moves to ERASE and latches exp_len = expose_time, with 0 replaced by 1.
  - start while busy is ignored.
- ERASE:
  - p_erase=1 for exactly ERASE_CYCLES cycles (k+1..k+ERASE_CYCLES), then EXPOSE.
- EXPOSE:
  - p_expose=1 for exactly exp_len cycles.
  - p_expose_clk is 0 on the first EXPOSE cycle and toggles every cycle after that.
  - p_expose_clk is forced 0 outside EXPOSE.
  - Then CONVERT with row 0.
- CONVERT:
  - p_row_select = one-hot(row); row 0 is bit 0.
  - p_dRamp counts 0,1,...,2^RAMP_WIDTH-1, one step per cycle, for 2^RAMP_WIDTH cycles. After the maximum it moves to READ.
- READ:
  - p_row_select is held.
  - p_dRamp holds the maximum code.
  - row_valid=1.
  - Stays until row_valid && row_ready at an edge (the handshake). row_ready may be high before row_valid; this gives a one-cycle READ.
- After a handshake:
  - If row < PIXEL_ARRAY_HEIGHT-1: row+1, CONVERT, p_dRamp restarts at 0.
  - Otherwise frame end: frame_done=1 for the following single cycle.
    - continuous=1 at that edge: next state ERASE, exp_len re-latched from expose_time.
    - continuous=0: next state IDLE.
- Row index width is ceil(log2(PIXEL_ARRAY_HEIGHT)), minimum 1. It wraps to 0 only at frame end.
- Ramp counter width is RAMP_WIDTH+0. The end condition is detected on the all-ones code, not on overflow.
- Frame length with row_ready held high, measured from start edge k:
  - last READ cycle = k + ERASE_CYCLES + exp_len + PIXEL_ARRAY_HEIGHT*(2^RAMP_WIDTH+1);
  - frame_done on the next cycle.
- Output exclusivity: at most one of p_erase, p_expose, row-select activity is active in any cycle.
- start and continuous changes mid-frame have no effect except continuous at frame end.

Test Plan:
1. Defaults, expose_time=10, row_ready=1, start pulse at edge k:
   - p_erase high k+1..k+5;
   - p_expose high k+6..k+15, with p_expose_clk 0,1,0,1,...;
   - p_row_select 0001, 0010, 0100, 1000, each with ramp 0..255;
   - last READ at k+1043; frame_done at k+1044; busy falls at k+1044.
2. Backpressure: row_ready=0 for 20 cycles at row 1's READ:
   - row_valid, p_row_select=0010 and p_dRamp=255 are held 20 cycles;
   - row 2 starts at p_dRamp=0 the cycle after the handshake;
   - frame_done is delayed exactly 20 cycles.
3. continuous=1: frame_done pulse is followed immediately by p_erase=1 with no IDLE cycle; new expose_time=3 gives a 3-cycle p_expose in the second frame.
4. expose_time=0: p_expose high exactly 1 cycle. start held high during a frame: no restart and no timing change.
5. reset pulled low during CONVERT of row 2 (mid-ramp):
   - all outputs 0 immediately, without waiting for a clock;
   - after release plus a start pulse, the frame restarts at ERASE with row 0.
6. RAMP_WIDTH=4, PIXEL_ARRAY_HEIGHT=8, ERASE_CYCLES=1, expose_time=2, row_ready=1: ramp 0..15, rows 1..128 one-hot, frame_done at k+1+2+8*17+1 = k+140.
